// File: rtl/intercon_master_mux_pkg.sv
// Shared types for the Wishbone master multiplexer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: bus-ownership FSM encoding, wait-counter width, default master count.
`ifndef INTERCON_MASTER_NUM
`define INTERCON_MASTER_NUM 2
`endif

package intercon_master_mux_pkg;

    // Bus ownership phases. RELEASE is a dead cycle that lets the peer
    // arbiter advance its rotation before the next grant is taken.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int WAIT_W = 8;

endpackage

// File: rtl/intercon_master_mux_if.sv
// Bundle of master-side, arbiter and shared slave-side Wishbone signals.
// Latency: n/a (wiring only).
// Backpressure: slave stalls a master by withholding s_ack/s_err.
// Modports: master = the multiplexer (it masters the shared slave bus);
//           slave  = the environment (bus masters, arbiter, target slave).
`ifndef INTERCON_MASTER_NUM
`define INTERCON_MASTER_NUM 2
`endif

interface intercon_master_mux_if #(
    parameter int MASTERS = `INTERCON_MASTER_NUM,
    parameter int AW      = 32,
    parameter int DW      = 32
);
    // per-master request side, master i owns slice i
    logic [MASTERS-1:0]        m_cyc;
    logic [MASTERS-1:0]        m_stb;
    logic [MASTERS-1:0]        m_we;
    logic [MASTERS*AW-1:0]     m_adr;
    logic [MASTERS*DW-1:0]     m_dat_w;
    logic [MASTERS*DW/8-1:0]   m_sel;
    logic [MASTERS-1:0]        m_ack;
    logic [MASTERS-1:0]        m_err;
    logic [DW-1:0]             m_dat_r;
    // arbiter handshake
    logic [MASTERS-1:0]        arb_request;
    logic [MASTERS-1:0]        arb_grant;
    // shared slave side
    logic                      s_cyc;
    logic                      s_stb;
    logic                      s_we;
    logic [AW-1:0]             s_adr;
    logic [DW-1:0]             s_dat_w;
    logic [DW/8-1:0]           s_sel;
    logic                      s_ack;
    logic                      s_err;
    logic [DW-1:0]             s_dat_r;

    modport master (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
        output m_ack, m_err, m_dat_r,
        output arb_request,
        input  arb_grant,
        output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
        input  s_ack, s_err, s_dat_r
    );

    modport slave (
        output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
        input  m_ack, m_err, m_dat_r,
        input  arb_request,
        output arb_grant,
        input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
        output s_ack, s_err, s_dat_r
    );
endinterface

// File: rtl/intercon_onehot_mux.sv
// Parameterised AND-OR multiplexer driven by a one-hot (or zero) select.
// Latency: combinational.
// Backpressure: none; an all-zero select yields an all-zero output.
// Ports: sel[N] one-hot select, din[N*W] flattened inputs (slice i = input i), dout[W].
module intercon_onehot_mux #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] din,
    output logic [W-1:0]   dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) begin
            dout = dout | (din[i*W +: W] & {W{sel[i]}});
        end
    end

endmodule

// File: rtl/intercon_master_mux.sv
// Routes the granted Wishbone master onto a shared slave bus and returns ack/err/data.
// Latency: grant in cycle N -> slave bus driven in N+1; ack/err/data paths combinational.
// Backpressure: slave stalls via s_ack/s_err; a stalled strobe is errored after TIMEOUT cycles.
// Ports: clk, rst (async active-low), bus (interface, master modport), owner (registered one-hot owner).
`ifndef INTERCON_MASTER_NUM
`define INTERCON_MASTER_NUM 2
`endif

module intercon_master_mux
    import intercon_master_mux_pkg::*;
#(
    parameter int MASTERS = `INTERCON_MASTER_NUM,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    intercon_master_mux_if.master bus,
    output logic [MASTERS-1:0]  owner
);

    localparam int SW = DW / 8;
    // per-master mux field: {cyc, stb, we, adr, dat_w, sel}
    localparam int FW = 3 + AW + DW + SW;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [MASTERS-1:0]      owner_q, owner_d;
    logic [WAIT_W-1:0]       wait_q;
    logic [MASTERS-1:0]      own_sel;
    logic [MASTERS*FW-1:0]   mux_in;
    logic [FW-1:0]           mux_out;
    logic                    owner_cyc;
    logic                    timeout_hit;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign owner_cyc = |(bus.m_cyc & owner_q);

    // ---------------- next-state ----------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ST_IDLE: begin
                // a malformed multi-bit grant is ignored rather than guessed at
                if ($onehot(bus.arb_grant)) begin
                    state_d = ST_OWN;
                    owner_d = bus.arb_grant;
                end
            end
            ST_OWN: begin
                // burst lock: only the owner dropping cyc ends ownership
                if (!owner_cyc) begin
                    state_d = ST_RELEASE;
                    owner_d = '0;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
            end
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        own_sel         = '0;
        bus.arb_request = bus.m_cyc;
        bus.m_ack       = '0;
        bus.m_err       = '0;
        if (state_q == ST_OWN) begin
            own_sel         = owner_q;
            bus.arb_request = bus.m_cyc | owner_q;
            bus.m_ack       = {MASTERS{bus.s_ack}} & owner_q;
            bus.m_err       = {MASTERS{bus.s_err | timeout_hit}} & owner_q;
        end
    end

    always_comb begin
        mux_in = '0;
        for (int i = 0; i < MASTERS; i++) begin
            mux_in[i*FW +: FW] = {bus.m_cyc[i], bus.m_stb[i], bus.m_we[i],
                                  bus.m_adr[i*AW +: AW],
                                  bus.m_dat_w[i*DW +: DW],
                                  bus.m_sel[i*SW +: SW]};
        end
    end

    // own_sel is zero outside OWN, so the whole slave bus idles at zero there
    intercon_onehot_mux #(
        .N (MASTERS),
        .W (FW)
    ) u_bus_mux (
        .sel  (own_sel),
        .din  (mux_in),
        .dout (mux_out)
    );

    assign {bus.s_cyc, bus.s_stb, bus.s_we, bus.s_adr, bus.s_dat_w, bus.s_sel} = mux_out;
    assign bus.m_dat_r = bus.s_dat_r;
    assign owner       = owner_q;

    // a real slave response in the same cycle wins over the timeout
    assign timeout_hit = bus.s_stb & ~bus.s_ack & ~bus.s_err & (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
        end else if (!bus.s_stb || bus.s_ack || bus.s_err || timeout_hit) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_intercon_master_mux.sv
module tb_intercon_master_mux;

    localparam int M  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    localparam logic [AW-1:0] ADR0 = 32'h1000_00A0;
    localparam logic [AW-1:0] ADR1 = 32'h2000_00B1;
    localparam logic [DW-1:0] DAT0 = 32'hCAFE_0000;
    localparam logic [DW-1:0] DAT1 = 32'hBEEF_1111;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [M-1:0] owner;

    always #5 clk = ~clk;

    intercon_master_mux_if #(.MASTERS(M), .AW(AW), .DW(DW)) bus ();

    intercon_master_mux #(
        .MASTERS (M),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .owner (owner)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // one row = one clock cycle of inputs plus the outputs expected during it
    typedef struct {
        logic [1:0] cyc, stb, grant;
        logic       ack, err;
        logic [1:0] e_own;
        logic       e_cyc, e_stb;
        int         e_src;          // master whose address should be on s_adr, -1 = none
        logic [1:0] e_ack, e_err, e_req;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic [1:0] cyc, logic [1:0] stb, logic [1:0] grant,
                                logic ack, logic err, logic [1:0] e_own, logic e_cyc,
                                logic e_stb, int e_src, logic [1:0] e_ack,
                                logic [1:0] e_err, logic [1:0] e_req);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.grant = grant; v.ack = ack; v.err = err;
        v.e_own = e_own; v.e_cyc = e_cyc; v.e_stb = e_stb; v.e_src = e_src;
        v.e_ack = e_ack; v.e_err = e_err; v.e_req = e_req;
        return v;
    endfunction

    task automatic drive_fixed();
        bus.m_we    = 2'b10;
        bus.m_adr   = {ADR1, ADR0};
        bus.m_dat_w = {DAT1, DAT0};
        bus.m_sel   = {4'hC, 4'h3};
    endtask

    task automatic drive_idle();
        bus.m_cyc = '0; bus.m_stb = '0; bus.arb_grant = '0;
        bus.s_ack = 1'b0; bus.s_err = 1'b0; bus.s_dat_r = '0;
    endtask

    // reference model state: owning master (-1 none), release pending, stalled-strobe count
    int own_m;
    bit rel_m;
    int wc_m;

    logic [AW-1:0] r_adr [M];
    logic [DW-1:0] r_dat [M];

    initial begin
        logic [DW-1:0] sdr;
        drive_fixed();
        drive_idle();
        // hostile inputs while in reset: nothing may reach the outputs
        bus.m_cyc = 2'b11; bus.m_stb = 2'b11; bus.arb_grant = 2'b01; bus.s_ack = 1'b1;
        #12;
        chk("rst_owner", owner, 0);
        chk("rst_s_cyc", bus.s_cyc, 0);
        chk("rst_s_adr", bus.s_adr, 0);
        chk("rst_m_ack", bus.m_ack, 0);
        chk("rst_m_err", bus.m_err, 0);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;

        // ---------- table: grant latency, burst lock, release, ack/err, timeout ----------
        tbl[0]  = mk(2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, -1, 2'b00, 2'b00, 2'b00);
        tbl[1]  = mk(2'b11, 2'b00, 2'b11, 0, 0, 2'b00, 0, 0, -1, 2'b00, 2'b00, 2'b11);
        tbl[2]  = mk(2'b01, 2'b00, 2'b01, 0, 0, 2'b00, 0, 0, -1, 2'b00, 2'b00, 2'b01);
        tbl[3]  = mk(2'b11, 2'b01, 2'b10, 0, 0, 2'b01, 1, 1,  0, 2'b00, 2'b00, 2'b11);
        tbl[4]  = mk(2'b11, 2'b01, 2'b10, 1, 0, 2'b01, 1, 1,  0, 2'b01, 2'b00, 2'b11);
        tbl[5]  = mk(2'b11, 2'b01, 2'b10, 1, 0, 2'b01, 1, 1,  0, 2'b01, 2'b00, 2'b11);
        tbl[6]  = mk(2'b11, 2'b01, 2'b10, 1, 0, 2'b01, 1, 1,  0, 2'b01, 2'b00, 2'b11);
        tbl[7]  = mk(2'b11, 2'b01, 2'b10, 1, 0, 2'b01, 1, 1,  0, 2'b01, 2'b00, 2'b11);
        tbl[8]  = mk(2'b10, 2'b00, 2'b10, 0, 0, 2'b01, 0, 0,  0, 2'b00, 2'b00, 2'b11);
        tbl[9]  = mk(2'b10, 2'b10, 2'b10, 0, 0, 2'b00, 0, 0, -1, 2'b00, 2'b00, 2'b10);
        tbl[10] = mk(2'b10, 2'b10, 2'b10, 0, 0, 2'b00, 0, 0, -1, 2'b00, 2'b00, 2'b10);
        tbl[11] = mk(2'b10, 2'b10, 2'b00, 1, 0, 2'b10, 1, 1,  1, 2'b10, 2'b00, 2'b10);
        tbl[12] = mk(2'b10, 2'b10, 2'b00, 0, 1, 2'b10, 1, 1,  1, 2'b00, 2'b10, 2'b10);
        tbl[13] = mk(2'b10, 2'b10, 2'b00, 0, 0, 2'b10, 1, 1,  1, 2'b00, 2'b00, 2'b10);
        tbl[14] = mk(2'b10, 2'b10, 2'b00, 0, 0, 2'b10, 1, 1,  1, 2'b00, 2'b00, 2'b10);
        tbl[15] = mk(2'b10, 2'b10, 2'b00, 0, 0, 2'b10, 1, 1,  1, 2'b00, 2'b00, 2'b10);
        tbl[16] = mk(2'b10, 2'b10, 2'b00, 0, 0, 2'b10, 1, 1,  1, 2'b00, 2'b10, 2'b10);
        tbl[17] = mk(2'b10, 2'b10, 2'b00, 0, 0, 2'b10, 1, 1,  1, 2'b00, 2'b00, 2'b10);
        tbl[18] = mk(2'b00, 2'b00, 2'b00, 0, 0, 2'b10, 0, 0,  1, 2'b00, 2'b00, 2'b10);
        tbl[19] = mk(2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, -1, 2'b00, 2'b00, 2'b00);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.m_cyc = tbl[i].cyc; bus.m_stb = tbl[i].stb; bus.arb_grant = tbl[i].grant;
            bus.s_ack = tbl[i].ack; bus.s_err = tbl[i].err;
            sdr = 32'hD000_0000 + 32'(i);
            bus.s_dat_r = sdr;
            #1;
            chk($sformatf("t%0d_owner", i), owner, tbl[i].e_own);
            chk($sformatf("t%0d_s_cyc", i), bus.s_cyc, tbl[i].e_cyc);
            chk($sformatf("t%0d_s_stb", i), bus.s_stb, tbl[i].e_stb);
            chk($sformatf("t%0d_s_adr", i), bus.s_adr,
                tbl[i].e_src < 0 ? 0 : (tbl[i].e_src == 0 ? ADR0 : ADR1));
            chk($sformatf("t%0d_m_ack", i), bus.m_ack, tbl[i].e_ack);
            chk($sformatf("t%0d_m_err", i), bus.m_err, tbl[i].e_err);
            chk($sformatf("t%0d_arb_req", i), bus.arb_request, tbl[i].e_req);
            chk($sformatf("t%0d_m_dat_r", i), bus.m_dat_r, sdr);
        end

        // ---------- async reset in the middle of an owned cycle ----------
        @(negedge clk);
        bus.m_cyc = 2'b01; bus.m_stb = 2'b01; bus.arb_grant = 2'b01;
        bus.s_ack = 1'b0; bus.s_err = 1'b0;
        @(negedge clk);
        bus.arb_grant = 2'b00;
        #1;
        chk("ar_owner_pre", owner, 2'b01);
        chk("ar_s_cyc_pre", bus.s_cyc, 1);
        bus.s_ack = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        chk("ar_owner", owner, 0);
        chk("ar_s_cyc", bus.s_cyc, 0);
        chk("ar_s_stb", bus.s_stb, 0);
        chk("ar_s_adr", bus.s_adr, 0);
        chk("ar_m_ack", bus.m_ack, 0);
        chk("ar_m_err", bus.m_err, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.s_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("ar_idle_owner", owner, 0);
        chk("ar_idle_s_cyc", bus.s_cyc, 0);
        bus.arb_grant = 2'b01;
        @(negedge clk);
        bus.arb_grant = 2'b00;
        #1;
        chk("ar_regrant_owner", owner, 2'b01);

        // ---------- randomized run against the reference model ----------
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        own_m = -1; rel_m = 0; wc_m = 0;
        for (int c = 0; c < 400; c++) begin
            logic [M-1:0] e_own, e_ack, e_err, e_req;
            logic         e_cyc, e_stb, e_we, hit;
            logic [AW-1:0] e_adr;
            logic [DW-1:0] e_dat;
            logic [SW-1:0] e_sel;
            int            g;
            @(negedge clk);
            for (int k = 0; k < M; k++) begin
                bus.m_cyc[k] = ($urandom_range(0, 3) != 0);
                bus.m_stb[k] = $urandom_range(0, 1);
                bus.m_we[k]  = $urandom_range(0, 1);
                bus.m_sel[k*SW +: SW] = SW'($urandom);
                r_adr[k] = $urandom;
                r_dat[k] = $urandom;
                bus.m_adr[k*AW +: AW]   = r_adr[k];
                bus.m_dat_w[k*DW +: DW] = r_dat[k];
            end
            g = $urandom_range(0, 9);
            bus.arb_grant = (g < 4) ? 2'b00 : (g < 9) ? (2'b01 << $urandom_range(0, 1)) : 2'b11;
            bus.s_ack   = ($urandom_range(0, 3) == 0);
            bus.s_err   = ($urandom_range(0, 15) == 0);
            sdr         = $urandom;
            bus.s_dat_r = sdr;
            #1;
            if (own_m >= 0) begin
                e_own = M'(1) << own_m;
                e_cyc = bus.m_cyc[own_m];
                e_stb = bus.m_stb[own_m];
                e_we  = bus.m_we[own_m];
                e_adr = r_adr[own_m];
                e_dat = r_dat[own_m];
                e_sel = bus.m_sel[own_m*SW +: SW];
            end else begin
                e_own = '0; e_cyc = 0; e_stb = 0; e_we = 0;
                e_adr = '0; e_dat = '0; e_sel = '0;
            end
            hit   = e_stb && !bus.s_ack && !bus.s_err && (wc_m == TO - 1);
            e_ack = bus.s_ack ? e_own : '0;
            e_err = (bus.s_err || hit) ? e_own : '0;
            e_req = bus.m_cyc | e_own;
            chk("rnd_owner", owner, e_own);
            chk("rnd_s_cyc", bus.s_cyc, e_cyc);
            chk("rnd_s_stb", bus.s_stb, e_stb);
            chk("rnd_s_we", bus.s_we, e_we);
            chk("rnd_s_adr", bus.s_adr, e_adr);
            chk("rnd_s_dat_w", bus.s_dat_w, e_dat);
            chk("rnd_s_sel", bus.s_sel, e_sel);
            chk("rnd_m_ack", bus.m_ack, e_ack);
            chk("rnd_m_err", bus.m_err, e_err);
            chk("rnd_arb_req", bus.arb_request, e_req);
            chk("rnd_m_dat_r", bus.m_dat_r, sdr);
            // advance the model across the coming rising edge
            if (!e_stb || bus.s_ack || bus.s_err || hit) wc_m = 0;
            else wc_m++;
            if (own_m >= 0) begin
                if (!bus.m_cyc[own_m]) begin
                    own_m = -1;
                    rel_m = 1;
                end
            end else if (rel_m) begin
                rel_m = 0;
            end else if ($countones(bus.arb_grant) == 1) begin
                own_m = bus.arb_grant[1] ? 1 : 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/intercon_master_mux.md
INTERCON_MASTER_MUX -- requirements
Module: intercon_master_mux

Interface
REQ-001 SHALL have parameter MASTERS, default `INTERCON_MASTER_NUM, number of bus masters.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width; select width is DW/8.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for slave ack or err, range 1..255.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 m_cyc, m_stb, m_we  in  MASTERS each  per-master Wishbone controls; bit i belongs to master i.
REQ-008 m_adr  in  MASTERS*AW, m_dat_w  in  MASTERS*DW, m_sel  in  MASTERS*DW/8  flattened per-master fields; master i occupies slice i.
REQ-009 m_ack, m_err  out  MASTERS  per-master termination strobes.
REQ-010 m_dat_r  out  DW  read data, broadcast to all masters.
REQ-011 arb_request  out  MASTERS  request vector to the arbiter.
REQ-012 arb_grant  in  MASTERS  one-hot or zero grant from the arbiter.
REQ-013 s_cyc, s_stb, s_we  out  1; s_adr  out  AW; s_dat_w  out  DW; s_sel  out  DW/8  shared slave-side bus.
REQ-014 s_ack, s_err  in  1; s_dat_r  in  DW  shared slave-side response.
REQ-015 owner  out  MASTERS  registered one-hot current bus owner, zero when bus idle.

Function
REQ-016 arb_request SHALL equal m_cyc, except bits of owner, which SHALL be held high while state is OWN.
REQ-017 FSM states SHALL be IDLE, OWN, RELEASE.
REQ-018 IDLE: owner = 0; if arb_grant != 0, owner <= arb_grant, go OWN on next edge; arb_grant with more than one bit set SHALL be ignored (stay IDLE).
REQ-019 OWN: s_cyc/s_stb/s_we/s_adr/s_dat_w/s_sel SHALL be combinationally muxed from owner's slice; all are 0 outside OWN.
REQ-020 OWN: m_ack[i] = s_ack & owner[i]; m_err[i] = (s_err | timeout_hit) & owner[i]; non-owners SHALL see 0.
REQ-021 OWN -> RELEASE when owner's m_cyc samples low; owner cleared on that edge.
REQ-022 RELEASE SHALL last exactly one cycle, drive all s_* low, then go IDLE; this gives the arbiter one cycle to update its rotation.
REQ-023 Wait counter, 8 bits: clears on any cycle with s_stb low or with s_ack/s_err high; otherwise increments.
REQ-024 timeout_hit SHALL be asserted for one cycle when the counter equals TIMEOUT-1 with s_stb high and no s_ack/s_err; the counter then clears; s_ack and s_err take priority over timeout_hit in that cycle.
REQ-025 Grant-to-bus latency: arb_grant valid in cycle N gives s_cyc high in cycle N+1.
REQ-026 Ownership SHALL NOT change while the owner holds m_cyc, regardless of arb_grant or other requests (burst lock).
REQ-027 m_dat_r SHALL equal s_dat_r unconditionally.

Reset
REQ-028 With rst low, the block SHALL go to IDLE immediately; owner = 0, wait counter = 0, and all s_* outputs, m_ack and m_err SHALL be 0.
REQ-029 Reset asserted in OWN SHALL abort the cycle with no ack or err generated; after release the block starts in IDLE.

Structure
REQ-030 State encodings and the MASTERS default SHALL come from i2d_soc_defines.v (`INTERCON_MASTER_NUM).
REQ-031 The block SHALL be a peer of arbiter; arbiter SHALL NOT be instantiated inside it. One sub-module, intercon_onehot_mux (parameterised AND-OR mux), SHALL be used for the address, write-data, select and control fields.

Verification
REQ-032 MASTERS=2: m_cyc=01, arb_grant=01 in cycle N -> owner=01 and s_cyc=1 in cycle N+1, s_adr = master0 address.
REQ-033 Master0 holds m_cyc for 4 strobes while m_cyc=11 and arb_grant switches to 10 -> owner stays 01; RELEASE one cycle after master0 drops m_cyc; then owner=10.
REQ-034 s_ack pulse in OWN with owner=10 -> m_ack=10, m_err=00, m_dat_r = s_dat_r in the same cycle.
REQ-035 TIMEOUT=4, s_stb held with no s_ack -> m_err[owner] high in the 4th stb cycle, counter back to 0.
REQ-036 rst low mid-OWN -> all s_* outputs and owner go to 0 asynchronously; after rst goes high the FSM is in IDLE.
REQ-037 arb_grant=11 in IDLE -> no transition, s_cyc stays 0.
